// File: rtl/bta_serial_ctrl.sv
// Serial balanced-ternary adder: one 2-trit ripple slice is applied per cycle,
// LSB pair first, and the registered result appears together with a done pulse.
module bta_serial_ctrl #(
    parameter int NTRIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*NTRIT-1:0] a,
    input  logic [2*NTRIT-1:0] b,
    output logic [2*NTRIT-1:0] sum,
    output logic [1:0]         carry_out,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int W     = 2 * NTRIT;
    localparam int NPAIR = NTRIT / 2;
    localparam int IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    localparam logic [1:0] T_NEG  = 2'b01;
    localparam logic [1:0] T_ZERO = 2'b11;
    localparam logic [1:0] T_POS  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [1:0]    carry_r;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  work;
    logic [W-1:0]  work_next;
    logic [3:0]    lo_res;
    logic [3:0]    hi_res;
    logic          last_pair;
    logic          start_bad;

    function automatic logic signed [2:0] trit_val(input logic [1:0] t);
        case (t)
            T_NEG:   trit_val = -3'sd1;
            T_POS:   trit_val = 3'sd1;
            default: trit_val = 3'sd0;
        endcase
    endfunction

    // Returns {carry, digit} for one trit position.
    function automatic logic [3:0] trit_add(input logic [1:0] x, input logic [1:0] y,
                                            input logic [1:0] c);
        logic signed [2:0] s;
        s = trit_val(x) + trit_val(y) + trit_val(c);
        case (s)
            3'sb101: trit_add = {T_NEG,  T_ZERO};
            3'sb110: trit_add = {T_NEG,  T_POS};
            3'sb111: trit_add = {T_ZERO, T_NEG};
            3'sb001: trit_add = {T_ZERO, T_POS};
            3'sb010: trit_add = {T_POS,  T_NEG};
            3'sb011: trit_add = {T_POS,  T_ZERO};
            default: trit_add = {T_ZERO, T_ZERO};
        endcase
    endfunction

    function automatic logic has_illegal(input logic [W-1:0] v);
        has_illegal = 1'b0;
        for (int i = 0; i < NTRIT; i++) begin
            if (v[2*i +: 2] == 2'b00) has_illegal = 1'b1;
        end
    endfunction

    // Ripple slice over the current lowest pair of the shifting operand registers.
    assign lo_res    = trit_add(op_a[1:0], op_b[1:0], carry_r);
    assign hi_res    = trit_add(op_a[3:2], op_b[3:2], lo_res[3:2]);
    assign last_pair = (idx == IW'(NPAIR - 1));
    assign start_bad = has_illegal(a) || has_illegal(b);

    generate
        if (W == 4) begin : g_work_one_pair
            assign work_next = {hi_res[1:0], lo_res[1:0]};
        end else begin : g_work_shift
            assign work_next = {hi_res[1:0], lo_res[1:0], work[W-1:4]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = start_bad ? S_DONE : S_ADD;
            S_ADD:   if (last_pair) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_ADD:   busy = 1'b1;
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    // sum/carry_out only move on entry to DONE, so they stay stable between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_r   <= T_ZERO;
            op_a      <= '1;
            op_b      <= '1;
            work      <= '1;
            sum       <= '1;
            carry_out <= T_ZERO;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= b;
                        carry_r <= T_ZERO;
                        idx     <= '0;
                        if (start_bad) begin
                            err       <= 1'b1;
                            sum       <= '1;
                            carry_out <= T_ZERO;
                        end else begin
                            err <= 1'b0;
                        end
                    end
                end
                S_ADD: begin
                    op_a    <= op_a >> 4;
                    op_b    <= op_b >> 4;
                    carry_r <= hi_res[3:2];
                    work    <= work_next;
                    if (last_pair) begin
                        idx       <= '0;
                        sum       <= work_next;
                        carry_out <= hi_res[3:2];
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bta_serial_ctrl.sv
// Directed and randomized checks of the serial balanced-ternary adder (NTRIT = 8).
module tb_bta_serial_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic [1:0]  carry_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    bta_serial_ctrl #(.NTRIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 7; i >= 0; i--) begin
            case (v[2*i +: 2])
                2'b01:   r = r * 3 - 1;
                2'b10:   r = r * 3 + 1;
                default: r = r * 3;
            endcase
        end
        return r;
    endfunction

    // Nine balanced trits of a decimal total; the top trit is the carry.
    function automatic logic [17:0] enc(input int total);
        logic [17:0] r;
        int t;
        int rem;
        int d;
        t = total;
        r = '1;
        for (int i = 0; i < 9; i++) begin
            rem = ((t % 3) + 3) % 3;
            d   = (rem == 0) ? 0 : ((rem == 1) ? 1 : -1);
            r[2*i +: 2] = (d == 0) ? 2'b11 : ((d == 1) ? 2'b10 : 2'b01);
            t = (t - d) / 3;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_legal();
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       v[2*i +: 2] = 2'b01;
                1:       v[2*i +: 2] = 2'b11;
                default: v[2*i +: 2] = 2'b10;
            endcase
        end
        return v;
    endfunction

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] es, input logic [1:0] ec, input logic ee,
                          input int elat, input bit poke);
        logic [15:0] prev_sum;
        int lat;
        prev_sum = sum;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        lat = 1;
        if (elat > 1) begin
            check("busy_add", busy, 1);
            check("sum_hold", sum, prev_sum);
        end
        while (!done && lat < 20) begin
            if (poke && lat == 2) begin
                start = 1'b1;
                a = 16'hAAAA;
                b = 16'hAAAA;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, elat);
        check("sum", sum, es);
        check("carry_out", carry_out, ec);
        check("err", err, ee);
        check("busy_done", busy, 1);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("sum_stable", sum, es);
        check("carry_stable", carry_out, ec);
        check("err_stable", err, ee);
    endtask

    initial begin
        int seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [17:0] ref_v;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("rst_sum", sum, 16'hFFFF);
        check("rst_carry", carry_out, 2'b11);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'hFFFE, 16'hFFFE, 16'hFFF9, 2'b11, 1'b0, 5, 1'b0);
        run_op(16'hAAAA, 16'hAAAA, 16'hFFFD, 2'b10, 1'b0, 5, 1'b0);
        run_op(16'hFFFD, 16'hFFFD, 16'hFFF6, 2'b11, 1'b0, 5, 1'b1);
        run_op(16'hFFCF, 16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 1, 1'b0);
        run_op(16'hFFFE, 16'hFFFE, 16'hFFF9, 2'b11, 1'b0, 5, 1'b0);

        // Reset in the second ADD cycle.
        @(negedge clk);
        a = 16'hAAAA;
        b = 16'hAAAA;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("add2_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum", sum, 16'hFFFF);
        check("arst_carry", carry_out, 2'b11);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("no_done_after_rst", seen, 0);
        run_op(16'hFFFE, 16'hFFFD, 16'hFFFF, 2'b11, 1'b0, 5, 1'b0);

        for (int n = 0; n < 20; n++) begin
            ra = rand_legal();
            rb = rand_legal();
            ref_v = enc(to_int(ra) + to_int(rb));
            run_op(ra, rb, ref_v[15:0], ref_v[17:16], 1'b0, 5, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bta_serial_ctrl.md
BTA_SERIAL_CTRL -- requirements
Module: bta_serial_ctrl

Interface
REQ-001 SHALL have parameter NTRIT, default 8, the operand width in balanced-ternary trits; it SHALL be even and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to add a and b.
REQ-005 SHALL have port a, input, 2*NTRIT bits: operand A, 2 bits per trit, trit i at [2i+1:2i], LSB trit first.
REQ-006 SHALL have port b, input, 2*NTRIT bits: operand B, same packing as a.
REQ-007 SHALL have port sum, output, 2*NTRIT bits: registered result, same packing as a.
REQ-008 SHALL have port carry_out, output, 2 bits: final carry trit.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress, start ignored.
REQ-010 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have port err, output, 1 bit: illegal trit encoding was seen in the last accepted operands.

Function
REQ-012 SHALL use this trit encoding on all ports: 01 = -1, 11 = 0, 10 = +1, 00 = illegal.
REQ-013 SHALL implement the FSM states IDLE, ADD and DONE; busy = 1 in ADD and DONE; done = 1 only in DONE.
REQ-014 SHALL, in IDLE with start = 1, capture a and b at the clock edge, clear the internal carry to 0, clear the pair index to 0, clear err and enter ADD; a and b may then change without effect.
REQ-015 SHALL ignore start while in ADD or DONE; there is no queueing.
REQ-016 SHALL, in ADD, process one trit pair (trits 2k and 2k+1) per cycle, LSB pair first, using an internal 2-trit ripple slice with carry-in; NTRIT/2 ADD cycles in total.
REQ-017 SHALL, per trit, compute s = a_i + b_i + c in {-3..3} and map (digit, carry) as: -3 -> (0,-1), -2 -> (+1,-1), -1 -> (-1,0), 0 -> (0,0), +1 -> (+1,0), +2 -> (-1,+1), +3 -> (0,+1).
REQ-018 SHALL accumulate result pairs in an internal working register, hold sum and carry_out at their previous values during ADD, and update both in the same edge that enters DONE.
REQ-019 SHALL have a latency such that, with start sampled at edge 0, done = 1 in the cycle after edge NTRIT/2 and the FSM returns to IDLE at edge NTRIT/2+1.
REQ-020 SHALL hold sum, carry_out and err stable from DONE until the next accepted start.
REQ-021 SHALL, if any captured trit of a or b is 00, set err = 1, skip ADD, enter DONE at the next edge (done asserted 1 cycle after start), and load sum with all zero trits and carry_out with 11.
REQ-022 SHALL never drive the 00 encoding on sum or carry_out.
REQ-023 SHALL take the pair-index wrap (last pair) as the ADD -> DONE transition; an index beyond NTRIT/2-1 SHALL NOT be reachable.

Reset
REQ-024 SHALL, while rst_n = 0, force immediately (asynchronously) state = IDLE, busy = 0, done = 0, err = 0, sum = all 11, carry_out = 11, and internal carry and index = 0.
REQ-025 SHALL, on reset during ADD or DONE, abandon the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification (NTRIT = 8)
REQ-026 SHALL verify: a = 16'hFFFE (+1), b = 16'hFFFE, start pulse -> done in the 5th cycle after start, sum = 16'hFFF9 (+2), carry_out = 11, err = 0.
REQ-027 SHALL verify: a = b = 16'hAAAA (+3280) -> sum = 16'hFFFD (-1), carry_out = 10 (total 6560).
REQ-028 SHALL verify: a = 16'hFFFD (-1), b = 16'hFFFD -> sum = 16'hFFF6 (-2); a start asserted during ADD leaves the result and timing unchanged.
REQ-029 SHALL verify: a[5:4] = 00 -> err = 1, done 1 cycle after start, sum = 16'hFFFF, carry_out = 11; the next legal start clears err.
REQ-030 SHALL verify: rst_n asserted in the 2nd ADD cycle -> all outputs at reset values before the next clock edge, no done pulse; the following start with a = 16'hFFFE, b = 16'hFFFD gives sum = 16'hFFFF.
REQ-031 SHALL verify: a randomized legal operand sweep whose sum and carry_out match a decimal reference model.
